uart_csr_fifo: RTL and testbench

- Register block for the UART peripheral, sitting between the CPU local bus and the UART serial core.
- Holds configuration (enable, baud select, clock value) and buffers TX and RX characters in parametrised FIFOs.
- Reports levels and flags, records RX overrun, and raises one interrupt line.

---
 rtl/uart_csr_fifo.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_uart_csr_fifo.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_csr_fifo.sv
// -----------------------------------------------------------------------------
// uart_csr_fifo
//
// Register block for the UART peripheral. It sits between the CPU local bus
// and the UART serial core. It holds the configuration (enable, baud select,
// clock value) and buffers TX and RX characters in two circular FIFOs. It also
// reports levels and flags, records RX overrun and drives one registered
// interrupt line.
//
// Register map (byte addresses, full-width decode):
//   0x0 CTRL   : EN[0], TXCLR[2] (W1 pulse), RXCLR[3] (W1 pulse), BR[7:4],
//                CLK[15:8], TXIE[16], RXIE[17], OVIE[18]
//   0x4 STAT   : TBUSY[0], RXNE[1], TXFULL[2], TXEMPTY[3], RXFULL[4],
//                OVR[5] (sticky, W1C), TXLVL[15:8], RXLVL[23:16]
//   0x8 TXDATA : write pushes a character, reads return 0
//   0xC RXDATA : read returns the RX head and pops it
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   waddr/wdata/wen/wstrb/wready   bus write channel (wready tied to 1)
//   raddr/ren/rdata/rvalid         bus read channel, one-cycle latency
//   en_out/br_out/clk_out          CTRL fields for the serial core
//   tx_data/tx_valid/tx_ready      TX FIFO head handshake towards the core
//   tbusy_in                       transmitter busy flag from the core
//   rx_data/rx_valid               received character push strobe
//   irq                            registered interrupt
// -----------------------------------------------------------------------------

// Circular FIFO with a separate occupancy counter. Full and empty come from
// the count held at the start of the cycle, so a push into a full FIFO is
// dropped even when a pop happens in the same cycle.
module uart_csr_fifo_buf #(
   parameter int W     = 8,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       push,
   input  logic                       pop,
   input  logic [W-1:0]               din,
   output logic [W-1:0]               head,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] cnt_q;
   logic          do_push;
   logic          do_pop;

   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == CW'(DEPTH));
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign count   = cnt_q;

   // The head is forced to zero while empty so stale storage never leaks out.
   assign head = empty ? '0 : mem[rd_ptr];

   // NOTE: sequential state is updated with non-blocking assignments only, so
   // every flop samples the values from before the edge regardless of order.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt_q  <= '0;
      end else begin
         // DEPTH is a power of two, so the pointers wrap at DEPTH-1 naturally.
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + CW'(1);
            2'b01:   cnt_q <= cnt_q - CW'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // NOTE: the storage array has no reset; after reset or flush the count is
   // zero and the head is masked, so old contents can never be observed.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end
endmodule

module uart_csr_fifo #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int STRB_W   = DATA_W / 8,
   parameter int CHAR_W   = 8,
   parameter int TX_DEPTH = 16,
   parameter int RX_DEPTH = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              wen,
   input  logic [STRB_W-1:0] wstrb,
   output logic              wready,
   input  logic [ADDR_W-1:0] raddr,
   input  logic              ren,
   output logic [DATA_W-1:0] rdata,
   output logic              rvalid,
   output logic              en_out,
   output logic [3:0]        br_out,
   output logic [7:0]        clk_out,
   output logic [CHAR_W-1:0] tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   input  logic              tbusy_in,
   input  logic [CHAR_W-1:0] rx_data,
   input  logic              rx_valid,
   output logic              irq
);
   localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(0);
   localparam logic [ADDR_W-1:0] A_STAT   = ADDR_W'(4);
   localparam logic [ADDR_W-1:0] A_TXDATA = ADDR_W'(8);
   localparam logic [ADDR_W-1:0] A_RXDATA = ADDR_W'(12);
   localparam int TX_CW = $clog2(TX_DEPTH + 1);
   localparam int RX_CW = $clog2(RX_DEPTH + 1);

   // Configuration registers
   logic       en_q;
   logic [3:0] br_q;
   logic [7:0] clk_q;
   logic       txie_q;
   logic       rxie_q;
   logic       ovie_q;

   // Status state
   logic       ovr_q;
   logic       tbusy_q;

   // Decoded bus strobes
   logic       wr_ctrl;
   logic       wr_stat;
   logic       tx_push;
   logic       tx_clr;
   logic       rx_clr;
   logic       rx_pop;
   logic       tx_pop;
   logic       ovr_clr;

   // FIFO status
   logic [CHAR_W-1:0] tx_head;
   logic [CHAR_W-1:0] rx_head;
   logic [TX_CW-1:0]  tx_count;
   logic [RX_CW-1:0]  rx_count;
   logic              tx_full;
   logic              tx_empty;
   logic              rx_full;
   logic              rx_empty;

   logic [DATA_W-1:0] rd_mux;
   logic              unused_bits;

   assign wready = 1'b1;

   assign wr_ctrl = wen && (waddr == A_CTRL);
   assign wr_stat = wen && (waddr == A_STAT);
   assign tx_push = wen && (waddr == A_TXDATA) && wstrb[0];
   assign tx_clr  = wr_ctrl && wstrb[0] && wdata[2];
   assign rx_clr  = wr_ctrl && wstrb[0] && wdata[3];
   assign ovr_clr = wr_stat && wstrb[0] && wdata[5];
   // The FIFO ignores a pop while empty, so an RXDATA read of an empty FIFO
   // returns zero without disturbing the pointers.
   assign rx_pop  = ren && (raddr == A_RXDATA);
   assign tx_pop  = tx_valid && tx_ready;

   // Bus bits that no register field uses.
   assign unused_bits = ^{wdata[DATA_W-1:19], wdata[1], wstrb[STRB_W-1:3]};

   // ---------------------------------------------------------------- CTRL
   always_ff @(posedge clk) begin
      if (rst) begin
         en_q   <= 1'b0;
         br_q   <= 4'hF;
         clk_q  <= 8'h00;
         txie_q <= 1'b0;
         rxie_q <= 1'b0;
         ovie_q <= 1'b0;
      end else if (wr_ctrl) begin
         if (wstrb[0]) begin
            en_q <= wdata[0];
            br_q <= wdata[7:4];
         end
         if (wstrb[1]) clk_q <= wdata[15:8];
         if (wstrb[2]) begin
            txie_q <= wdata[16];
            rxie_q <= wdata[17];
            ovie_q <= wdata[18];
         end
      end
   end

   assign en_out  = en_q;
   assign br_out  = br_q;
   assign clk_out = clk_q;

   // ---------------------------------------------------------------- FIFOs
   uart_csr_fifo_buf #(
      .W     (CHAR_W),
      .DEPTH (TX_DEPTH)
   ) u_tx_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (tx_clr),
      .push  (tx_push),
      .pop   (tx_pop),
      .din   (wdata[CHAR_W-1:0]),
      .head  (tx_head),
      .count (tx_count),
      .full  (tx_full),
      .empty (tx_empty)
   );

   uart_csr_fifo_buf #(
      .W     (CHAR_W),
      .DEPTH (RX_DEPTH)
   ) u_rx_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (rx_clr),
      .push  (rx_valid),
      .pop   (rx_pop),
      .din   (rx_data),
      .head  (rx_head),
      .count (rx_count),
      .full  (rx_full),
      .empty (rx_empty)
   );

   // The head only advances on a pop, so tx_data holds while tx_ready is low.
   assign tx_valid = en_q && !tx_empty;
   assign tx_data  = tx_head;

   // ---------------------------------------------------------------- STAT
   always_ff @(posedge clk) begin
      if (rst) begin
         ovr_q   <= 1'b0;
         tbusy_q <= 1'b0;
      end else begin
         tbusy_q <= tbusy_in;
         // A new overrun takes priority over a clear in the same cycle.
         if (rx_valid && rx_full) ovr_q <= 1'b1;
         else if (ovr_clr)        ovr_q <= 1'b0;
      end
   end

   // ---------------------------------------------------------------- read
   // NOTE: every signal driven here gets a default first, so no path through
   // the case can leave a bit unassigned and infer a latch.
   always_comb begin
      rd_mux = '0;
      case (raddr)
         A_CTRL: begin
            rd_mux[0]     = en_q;
            rd_mux[7:4]   = br_q;
            rd_mux[15:8]  = clk_q;
            rd_mux[16]    = txie_q;
            rd_mux[17]    = rxie_q;
            rd_mux[18]    = ovie_q;
         end
         A_STAT: begin
            rd_mux[0]     = tbusy_q;
            rd_mux[1]     = !rx_empty;
            rd_mux[2]     = tx_full;
            rd_mux[3]     = tx_empty;
            rd_mux[4]     = rx_full;
            rd_mux[5]     = ovr_q;
            rd_mux[15:8]  = 8'(tx_count);
            rd_mux[23:16] = 8'(rx_count);
         end
         A_RXDATA: rd_mux[CHAR_W-1:0] = rx_head;
         default:  rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rvalid <= 1'b0;
         rdata  <= '0;
      end else begin
         rvalid <= ren;
         rdata  <= ren ? rd_mux : '0;
      end
   end

   // ---------------------------------------------------------------- irq
   always_ff @(posedge clk) begin
      if (rst) irq <= 1'b0;
      else     irq <= (txie_q && tx_empty) || (rxie_q && !rx_empty) || (ovie_q && ovr_q);
   end
endmodule

// File: tb/tb_uart_csr_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_csr_fifo
//
// Directed bench for uart_csr_fifo. Inputs change on the falling edge and
// outputs are sampled on the falling edge, half a cycle away from the active
// rising edge. Expected read data is queued when a read is issued and popped
// when rvalid returns; expected TX and RX characters are kept in queues that
// model the two FIFOs.
// -----------------------------------------------------------------------------
module tb_uart_csr_fifo;
   localparam logic [31:0] A_CTRL   = 32'h0;
   localparam logic [31:0] A_STAT   = 32'h4;
   localparam logic [31:0] A_TXDATA = 32'h8;
   localparam logic [31:0] A_RXDATA = 32'hC;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] waddr;
   logic [31:0] wdata;
   logic        wen;
   logic [3:0]  wstrb;
   logic        wready;
   logic [31:0] raddr;
   logic        ren;
   logic [31:0] rdata;
   logic        rvalid;
   logic        en_out;
   logic [3:0]  br_out;
   logic [7:0]  clk_out;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        tbusy_in;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        irq;

   int checks = 0;
   int errors = 0;

   logic [31:0] rd_q [$];   // expected read data, in issue order
   logic [7:0]  tx_q [$];   // expected TX characters
   logic [7:0]  rx_q [$];   // expected RX characters

   uart_csr_fifo dut (
      .clk      (clk),
      .rst      (rst),
      .waddr    (waddr),
      .wdata    (wdata),
      .wen      (wen),
      .wstrb    (wstrb),
      .wready   (wready),
      .raddr    (raddr),
      .ren      (ren),
      .rdata    (rdata),
      .rvalid   (rvalid),
      .en_out   (en_out),
      .br_out   (br_out),
      .clk_out  (clk_out),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .tbusy_in (tbusy_in),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .irq      (irq)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // All tasks start and end on a falling edge.
   task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
      waddr = addr;
      wdata = data;
      wstrb = strb;
      wen   = 1'b1;
      @(negedge clk);
      wen   = 1'b0;
      wstrb = 4'h0;
   endtask

   task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string tag);
      rd_q.push_back(exp);
      raddr = addr;
      ren   = 1'b1;
      @(negedge clk);
      ren   = 1'b0;
      check({tag, "_rvalid"}, {31'b0, rvalid}, 32'd1);
      check(tag, rdata, rd_q.pop_front());
   endtask

   task automatic rx_push(input logic [7:0] c);
      rx_data  = c;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   initial begin
      rst      = 1'b1;
      waddr    = '0;
      wdata    = '0;
      wen      = 1'b0;
      wstrb    = '0;
      raddr    = '0;
      ren      = 1'b0;
      tx_ready = 1'b0;
      tbusy_in = 1'b0;
      rx_data  = '0;
      rx_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // ---------------- 1. reset state
      check("rst_br", {28'b0, br_out}, 32'hF);
      check("rst_en", {31'b0, en_out}, 32'h0);
      check("rst_clk", {24'b0, clk_out}, 32'h0);
      check("rst_txv", {31'b0, tx_valid}, 32'h0);
      check("rst_irq", {31'b0, irq}, 32'h0);
      check("rst_rvalid", {31'b0, rvalid}, 32'h0);
      check("wready", {31'b0, wready}, 32'h1);
      rd(A_STAT, 32'h0000_0008, "rst_stat");
      rd(A_CTRL, 32'h0000_00F0, "rst_ctrl");
      @(negedge clk);
      check("idle_rvalid", {31'b0, rvalid}, 32'h0);
      check("idle_rdata", rdata, 32'h0);
      // TBUSY is tbusy_in delayed by one cycle
      tbusy_in = 1'b1;
      @(negedge clk);
      rd(A_STAT, 32'h0000_0009, "tbusy_stat");
      tbusy_in = 1'b0;
      @(negedge clk);
      // unmapped writes are ignored, unmapped and TXDATA reads return 0
      wr(32'h10, 32'hFFFF_FFFF, 4'hF);
      rd(32'h10, 32'h0, "unmapped_rd");
      rd(A_TXDATA, 32'h0, "txdata_rd");
      rd(A_CTRL, 32'h0000_00F0, "ctrl_after_unmapped");

      // ---------------- 2. TX FIFO fill with EN=0, then drain
      for (int i = 0; i < 16; i++) begin
         wr(A_TXDATA, 32'h41 + 32'(i), 4'b0001);
         tx_q.push_back(8'h41 + 8'(i));
      end
      wr(A_TXDATA, 32'h99, 4'b0001);   // full: dropped
      check("txv_en0", {31'b0, tx_valid}, 32'h0);
      rd(A_STAT, 32'h0000_1004, "tx_full_stat");
      tx_ready = 1'b1;
      wr(A_CTRL, 32'h0000_00F1, 4'b0001);
      for (int i = 0; i < 16; i++) begin
         check($sformatf("tx_valid_%0d", i), {31'b0, tx_valid}, 32'h1);
         check($sformatf("tx_data_%0d", i), {24'b0, tx_data}, {24'b0, tx_q.pop_front()});
         @(negedge clk);
      end
      check("tx_drained", {31'b0, tx_valid}, 32'h0);
      tx_ready = 1'b0;

      // ---------------- 3. RX overrun
      wr(A_CTRL, 32'h0004_00F1, 4'b0101);   // OVIE=1
      for (int i = 0; i < 17; i++) begin
         rx_push(8'(i));
         if (i < 16) rx_q.push_back(8'(i));
      end
      check("irq_lag", {31'b0, irq}, 32'h0);
      @(negedge clk);
      check("irq_ovr", {31'b0, irq}, 32'h1);
      rd(A_STAT, 32'h0010_003A, "ovr_stat");
      for (int i = 0; i < 16; i++)
         rd(A_RXDATA, {24'b0, rx_q.pop_front()}, $sformatf("rx_rd_%0d", i));
      rd(A_RXDATA, 32'h0, "rx_rd_empty");
      wr(A_STAT, 32'h0000_0020, 4'b0001);
      rd(A_STAT, 32'h0000_0008, "ovr_clr_stat");
      check("irq_clr", {31'b0, irq}, 32'h0);

      // ---------------- 4. pointer wrap with simultaneous push and pop
      for (int i = 0; i < 5; i++) begin
         rx_push(8'hA0 + 8'(i));
         rx_q.push_back(8'hA0 + 8'(i));
      end
      for (int i = 0; i < 40; i++) begin
         rx_data  = 8'hB0 + 8'(i);
         rx_valid = 1'b1;
         raddr    = A_RXDATA;
         ren      = 1'b1;
         rd_q.push_back({24'b0, rx_q.pop_front()});
         rx_q.push_back(8'hB0 + 8'(i));
         @(negedge clk);
         check($sformatf("wrap_rvalid_%0d", i), {31'b0, rvalid}, 32'h1);
         check($sformatf("wrap_data_%0d", i), rdata, rd_q.pop_front());
      end
      rx_valid = 1'b0;
      ren      = 1'b0;
      rd(A_STAT, 32'h0005_000A, "wrap_lvl");
      for (int i = 0; i < 5; i++)
         rd(A_RXDATA, {24'b0, rx_q.pop_front()}, $sformatf("wrap_tail_%0d", i));

      // ---------------- 5. flush
      wr(A_CTRL, 32'h0004_00F0, 4'b0101);   // EN=0
      for (int i = 0; i < 8; i++) wr(A_TXDATA, 32'hC0 + 32'(i), 4'b0001);
      rd(A_STAT, 32'h0000_0800, "tx8_stat");
      wr(A_CTRL, 32'h0004_00F1, 4'b0001);   // EN=1, core stalled
      for (int i = 0; i < 3; i++) begin
         check($sformatf("stall_valid_%0d", i), {31'b0, tx_valid}, 32'h1);
         check($sformatf("stall_data_%0d", i), {24'b0, tx_data}, 32'hC0);
         @(negedge clk);
      end
      // flush lands on the same edge as a TX pop
      tx_ready = 1'b1;
      wr(A_CTRL, 32'h0004_00F5, 4'b0001);
      check("flush_txv", {31'b0, tx_valid}, 32'h0);
      rd(A_STAT, 32'h0000_0008, "flush_stat");
      // a push after the flush lands at the reset pointer and is the new head
      wr(A_TXDATA, 32'h77, 4'b0001);
      check("post_flush_v", {31'b0, tx_valid}, 32'h1);
      check("post_flush_d", {24'b0, tx_data}, 32'h77);
      @(negedge clk);
      check("post_flush_pop", {31'b0, tx_valid}, 32'h0);
      tx_ready = 1'b0;
      // RX flush together with an incoming character
      for (int i = 0; i < 3; i++) rx_push(8'hE0 + 8'(i));
      rx_data  = 8'hEE;
      rx_valid = 1'b1;
      wr(A_CTRL, 32'h0004_00F9, 4'b0001);
      rx_valid = 1'b0;
      rd(A_STAT, 32'h0000_0008, "rxclr_stat");

      // ---------------- 6. strobes and reset mid-read
      wr(A_CTRL, 32'h0003_12A5, 4'b0010);
      check("strb_clk", {24'b0, clk_out}, 32'h12);
      check("strb_br", {28'b0, br_out}, 32'hF);
      check("strb_en", {31'b0, en_out}, 32'h1);
      rd(A_CTRL, 32'h0004_12F1, "strb_ctrl");
      wr(A_TXDATA, 32'h55, 4'b0001);
      rx_push(8'h66);
      check("pre_rst_txv", {31'b0, tx_valid}, 32'h1);
      // reset lands on the edge that would have returned the read
      raddr = A_CTRL;
      ren   = 1'b1;
      rst   = 1'b1;
      @(negedge clk);
      ren   = 1'b0;
      check("mid_rst_rvalid", {31'b0, rvalid}, 32'h0);
      check("mid_rst_rdata", rdata, 32'h0);
      check("mid_rst_en", {31'b0, en_out}, 32'h0);
      check("mid_rst_br", {28'b0, br_out}, 32'hF);
      check("mid_rst_clk", {24'b0, clk_out}, 32'h0);
      check("mid_rst_txv", {31'b0, tx_valid}, 32'h0);
      check("mid_rst_txd", {24'b0, tx_data}, 32'h0);
      check("mid_rst_irq", {31'b0, irq}, 32'h0);
      rst = 1'b0;
      @(negedge clk);
      rd(A_STAT, 32'h0000_0008, "post_rst_stat");
      rd(A_CTRL, 32'h0000_00F0, "post_rst_ctrl");
      check("sb_empty", 32'(rd_q.size()), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
